// File: rtl/regfile_pkg.sv
// Shared constants, index/data types and the popcount helper for the register file.
package regfile_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_DEPTH = 32;
    localparam int POP_MAX   = 256;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] reg_data_t;

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int DEPTH = REG_DEPTH,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(DEPTH);

    logic [NRD*AW-1:0]    rd_idx;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_idx;
    logic [NWR*WIDTH-1:0] wr_data;
    logic                 alloc_req;
    logic [AW-1:0]        alloc_idx;
    logic                 alloc_ack;
    logic [AW:0]          busy_cnt;

    modport master (
        output rd_idx, wr_en, wr_idx, wr_data, alloc_req, alloc_idx,
        input  rd_data, rd_busy, alloc_ack, busy_cnt
    );

    modport slave (
        input  rd_idx, wr_en, wr_idx, wr_data, alloc_req, alloc_idx,
        output rd_data, rd_busy, alloc_ack, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: destination allocation, writeback release and the busy population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = REG_DEPTH,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_idx,
    input  logic              alloc_req,
    input  logic [AW-1:0]     alloc_idx,
    output logic              alloc_ack,
    output logic [DEPTH-1:0]  busy,
    output logic [AW:0]       busy_cnt
);

    logic [DEPTH-1:0]   clearing;
    logic [DEPTH-1:0]   busy_nxt;
    logic [POP_MAX-1:0] pop_vec;
    logic [AW:0]        busy_cnt_nxt;

    always_comb begin
        clearing = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_idx[w*AW +: AW] != '0)) begin
                clearing[wr_idx[w*AW +: AW]] = 1'b1;
            end
        end

        // An in-flight destination that is being written back this cycle may be reallocated.
        alloc_ack = !rst && alloc_req &&
                    ((alloc_idx == '0) || !busy[alloc_idx] || clearing[alloc_idx]);

        busy_nxt = busy & ~clearing;
        if (alloc_ack && (alloc_idx != '0)) begin
            busy_nxt[alloc_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;

        pop_vec              = '0;
        pop_vec[DEPTH-1:0]   = busy_nxt;
        busy_cnt_nxt         = (AW+1)'(popcount(pop_vec));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard; r0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int DEPTH = REG_DEPTH,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic [NRD*WIDTH-1:0] rd_data_c;
    logic [NRD-1:0]       rd_busy_c;
    logic [AW-1:0]        ri;

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bus.wr_en),
        .wr_idx    (bus.wr_idx),
        .alloc_req (bus.alloc_req),
        .alloc_idx (bus.alloc_idx),
        .alloc_ack (bus.alloc_ack),
        .busy      (busy),
        .busy_cnt  (bus.busy_cnt)
    );

    // Later ports are assigned last, so the highest-numbered port wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && (bus.wr_idx[w*AW +: AW] != '0)) begin
                    mem[bus.wr_idx[w*AW +: AW]] <= bus.wr_data[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ri        = '0;
        for (int p = 0; p < NRD; p++) begin
            ri = bus.rd_idx[p*AW +: AW];
            if (ri != '0) begin
                rd_data_c[p*WIDTH +: WIDTH] = mem[ri];
                rd_busy_c[p]                = busy[ri];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NWR; w++) begin
                    if (!rst && bus.wr_en[w] && (bus.wr_idx[w*AW +: AW] == ri)) begin
                        rd_data_c[p*WIDTH +: WIDTH] = bus.wr_data[w*WIDTH +: WIDTH];
                        rd_busy_c[p]                = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, corner sequences, random vs. model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(W), .DEPTH(D), .NRD(NR), .NWR(NW)) bus ();

    regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(NR), .NWR(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wi0;
        logic [31:0] wd0;
        logic [4:0]  wi1;
        logic [31:0] wd1;
        logic        areq;
        logic [4:0]  ai;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic        e_b0;
        logic        e_b1;
        logic        e_ack;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [10];

    logic [31:0] mdata [D];
    bit          mbusy [D];
    int          mcount;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wen, input logic [4:0] wi0, input logic [31:0] wd0,
                         input logic [4:0] wi1, input logic [31:0] wd1, input logic areq,
                         input logic [4:0] ai, input logic [4:0] r0, input logic [4:0] r1);
        bus.wr_en     = wen;
        bus.wr_idx    = {wi1, wi0};
        bus.wr_data   = {wd1, wd0};
        bus.alloc_req = areq;
        bus.alloc_idx = ai;
        bus.rd_idx    = {r1, r0};
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rnd_idx();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        tbl[0] = '{2'b01, 5'd3, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd0,
                   32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[1] = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0,
                   32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0};
        tbl[2] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd3,
                   32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 6'd0};
        tbl[3] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0,
                   32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[4] = '{2'b01, 5'd7, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                   32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 5'd3,
                   32'hA5, 32'h12345678, 1'b0, 1'b0, 1'b1, 6'd0};
        tbl[6] = '{2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b1, 5'd9, 5'd3, 5'd0,
                   32'h12345678, 32'h0, 1'b0, 1'b0, 1'b1, 6'd1};
        tbl[7] = '{2'b11, 5'd4, 32'h1111, 5'd4, 32'h2222, 1'b1, 5'd0, 5'd9, 5'd0,
                   32'h55, 32'h0, 1'b1, 1'b0, 1'b1, 6'd1};
        tbl[8] = '{2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 1'b0, 5'd0, 5'd4, 5'd0,
                   32'h2222, 32'h0, 1'b0, 1'b0, 1'b0, 6'd1};
        tbl[9] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd4,
                   32'h2, 32'h2222, 1'b0, 1'b0, 1'b0, 6'd0};

        rst = 1'b1;
        idle(5'd0, 5'd0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_cnt", 32'(bus.busy_cnt), 32'd0);
        chk("reset_ack", 32'(bus.alloc_ack), 32'd0);
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].wen, tbl[i].wi0, tbl[i].wd0, tbl[i].wi1, tbl[i].wd1,
                  tbl[i].areq, tbl[i].ai, tbl[i].r0, tbl[i].r1);
            #1;
            chk($sformatf("row%0d_d0", i),  bus.rd_data[31:0],        tbl[i].e_d0);
            chk($sformatf("row%0d_d1", i),  bus.rd_data[63:32],       tbl[i].e_d1);
            chk($sformatf("row%0d_b0", i),  32'(bus.rd_busy[0]),      32'(tbl[i].e_b0));
            chk($sformatf("row%0d_b1", i),  32'(bus.rd_busy[1]),      32'(tbl[i].e_b1));
            chk($sformatf("row%0d_ack", i), 32'(bus.alloc_ack),       32'(tbl[i].e_ack));
            chk($sformatf("row%0d_cnt", i), 32'(bus.busy_cnt),        32'(tbl[i].e_cnt));
            tick();
        end

        // Same-cycle write and read of r6, with r6 busy.
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd0, 5'd0);
        #1;
        chk("byp_alloc_ack", 32'(bus.alloc_ack), 32'd1);
        tick();
        drive(2'b01, 5'd6, 32'hCAFE, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd6);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_d0", bus.rd_data[31:0], 32'hCAFE);
        chk("byp_same_b0", 32'(bus.rd_busy[0]), 32'd0);
        chk("byp_same_d1", bus.rd_data[63:32], 32'hCAFE);
`else
        chk("byp_same_d0", bus.rd_data[31:0], 32'h0);
        chk("byp_same_b0", 32'(bus.rd_busy[0]), 32'd1);
        chk("byp_same_d1", bus.rd_data[63:32], 32'h0);
`endif
        chk("byp_same_cnt", 32'(bus.busy_cnt), 32'd1);
        tick();
        idle(5'd6, 5'd0);
        #1;
        chk("byp_next_d0", bus.rd_data[31:0], 32'hCAFE);
        chk("byp_next_b0", 32'(bus.rd_busy[0]), 32'd0);
        chk("byp_next_cnt", 32'(bus.busy_cnt), 32'd0);
        tick();

        // Asynchronous reset mid-cycle with a write and allocation pending.
        drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd11, 5'd0, 5'd0);
        tick();
        idle(5'd5, 5'd11);
        #1;
        chk("pre_rst_d0", bus.rd_data[31:0], 32'hDEADBEEF);
        chk("pre_rst_b1", 32'(bus.rd_busy[1]), 32'd1);
        chk("pre_rst_cnt", 32'(bus.busy_cnt), 32'd1);
        #2;
        drive(2'b01, 5'd5, 32'h77, 5'd0, 32'h0, 1'b1, 5'd12, 5'd5, 5'd11);
        rst = 1'b1;
        #1;
        chk("rst_async_d0", bus.rd_data[31:0], 32'h0);
        chk("rst_async_b0", 32'(bus.rd_busy[0]), 32'd0);
        chk("rst_async_b1", 32'(bus.rd_busy[1]), 32'd0);
        chk("rst_async_cnt", 32'(bus.busy_cnt), 32'd0);
        chk("rst_async_ack", 32'(bus.alloc_ack), 32'd0);
        tick();
        idle(5'd5, 5'd12);
        rst = 1'b0;
        #1;
        chk("post_rst_d0", bus.rd_data[31:0], 32'h0);
        chk("post_rst_b1", 32'(bus.rd_busy[1]), 32'd0);
        chk("post_rst_cnt", 32'(bus.busy_cnt), 32'd0);
        tick();

        for (int i = 0; i < D; i++) begin
            mdata[i] = '0;
            mbusy[i] = 1'b0;
        end
        mcount = 0;

        for (int n = 0; n < 400; n++) begin
            logic [1:0]  wen;
            logic [4:0]  wi [2];
            logic [31:0] wd [2];
            logic        areq;
            logic [4:0]  ai;
            logic [4:0]  ri [2];
            logic [31:0] ed;
            logic        eb;
            bit          clr [D];
            logic        eack;

            wen   = 2'($urandom_range(0, 3));
            wi[0] = rnd_idx();
            wi[1] = rnd_idx();
            wd[0] = $urandom;
            wd[1] = $urandom;
            areq  = 1'($urandom_range(0, 1));
            ai    = rnd_idx();
            ri[0] = rnd_idx();
            ri[1] = rnd_idx();
            drive(wen, wi[0], wd[0], wi[1], wd[1], areq, ai, ri[0], ri[1]);
            #1;

            for (int i = 0; i < D; i++) clr[i] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                if (wen[w] && wi[w] != 0) clr[wi[w]] = 1'b1;
            end
            eack = areq && (ai == 0 || !mbusy[ai] || clr[ai]);

            for (int p = 0; p < 2; p++) begin
                ed = (ri[p] == 0) ? 32'h0 : mdata[ri[p]];
                eb = (ri[p] == 0) ? 1'b0 : mbusy[ri[p]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < 2; w++) begin
                    if (wen[w] && wi[w] == ri[p] && ri[p] != 0) begin
                        ed = wd[w];
                        eb = 1'b0;
                    end
                end
`endif
                chk($sformatf("rnd%0d_d%0d", n, p), bus.rd_data[p*32 +: 32], ed);
                chk($sformatf("rnd%0d_b%0d", n, p), 32'(bus.rd_busy[p]), 32'(eb));
            end
            chk($sformatf("rnd%0d_ack", n), 32'(bus.alloc_ack), 32'(eack));
            chk($sformatf("rnd%0d_cnt", n), 32'(bus.busy_cnt), 32'(mcount));
            tick();

            for (int w = 0; w < 2; w++) begin
                if (wen[w] && wi[w] != 0) mdata[wi[w]] = wd[w];
            end
            for (int i = 1; i < D; i++) begin
                if (clr[i]) mbusy[i] = 1'b0;
            end
            if (eack && ai != 0) mbusy[ai] = 1'b1;
            mcount = 0;
            for (int i = 1; i < D; i++) mcount += int'(mbusy[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
